// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared state encoding and sizing constants for the round-robin arbiter
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_REQ       = 4;
    localparam int IDX_W       = 2;
    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - requester/grant bundle between requesters (master) and the arbiter (slave)
interface rr_arbiter4_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          timeout_o;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, timeout_o
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, timeout_o
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first request at or above ptr, else lowest request
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N  = N_REQ,
    parameter int IW = IDX_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0] below;
    logic [N-1:0] masked;
    logic [N-1:0] cand;

    always_comb begin
        below  = (N'(1) << ptr) - N'(1);
        masked = req & ~below;
        cand   = (masked != '0) ? masked : req;
        // x & -x isolates the lowest set bit
        sel    = cand & (~cand + N'(1));
        any    = |req;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - registered round-robin arbiter with grant hold; ARB_TIMEOUT_EN bounds grant length
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int N       = N_REQ,
    parameter int IW      = IDX_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    rr_arbiter4_if.slave bus
);
    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [N-1:0]  gnt, gnt_nxt;
    logic          gnt_valid, gnt_valid_nxt;
    logic [IW-1:0] gnt_id, gnt_id_nxt;
    logic          timeout_q, timeout_nxt;

    logic [N-1:0]  pick_sel;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          rel_req;
    logic          to_force;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .sel (pick_sel),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign rel_req = bus.done | ~bus.req[gnt_id];

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] hold_cnt;

    // Held at zero while idle so it reads 0 on the first BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                hold_cnt <= '0;
        else if (state == IDLE) hold_cnt <= '0;
        else                    hold_cnt <= hold_cnt + CW'(1);
    end

    assign to_force = (state == BUSY) && !rel_req && (hold_cnt == CW'(TIMEOUT - 1));
`else
    assign to_force = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_nxt       = gnt;
        gnt_valid_nxt = gnt_valid;
        gnt_id_nxt    = gnt_id;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_nxt       = pick_sel;
                    gnt_id_nxt    = pick_idx;
                    gnt_valid_nxt = 1'b1;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (rel_req || to_force) begin
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = gnt_id + IW'(1);
                    timeout_nxt   = to_force;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= gnt_valid_nxt;
            gnt_id    <= gnt_id_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_valid = gnt_valid;
    assign bus.gnt_id    = gnt_id;
    assign bus.timeout_o = timeout_q;
endmodule
